simon_sequencer: RTL

- Control and sequencing engine for the Simon game; the counterpart of the Simon datapath/memory.
- Issues all writes into, and reads out of, the 64-entry 4-bit pattern memory.
- Drives the game FSM: player input, sequence playback, player repeat, game over.
- Owns the sequence-length counter and the playback/repeat index. Emits memory port controls, pattern LEDs and mode LEDs.

---
 rtl/simon_pkg.sv | 42 ++++
 rtl/simon_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game sequencer.
// Holds the state encoding, mode LED constants and pattern legality rule.
package simon_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_INPUT,
      ST_PLAYBACK,
      ST_REPEAT,
      ST_DONE
   } state_e;

   localparam logic [3:0] MODE_INPUT    = 4'b0001;
   localparam logic [3:0] MODE_PLAYBACK = 4'b0010;
   localparam logic [3:0] MODE_REPEAT   = 4'b0100;
   localparam logic [3:0] MODE_DONE     = 4'b1000;

   function automatic logic [3:0] mode_leds_of(input state_e s);
      logic [3:0] m;
      m = MODE_INPUT;
      unique case (s)
         ST_INPUT:    m = MODE_INPUT;
         ST_PLAYBACK: m = MODE_PLAYBACK;
         ST_REPEAT:   m = MODE_REPEAT;
         ST_DONE:     m = MODE_DONE;
         default:     m = MODE_INPUT;
      endcase
      return m;
   endfunction

   // Hard mode accepts anything; easy mode wants exactly one bit set.
   function automatic logic is_legal(
      input logic [31:0] pat,
      input logic        hard
   );
      return hard ||
         ((pat != '0) && ((pat & (pat - 32'd1)) == '0));
   endfunction

endpackage

// File: rtl/simon_sequencer.sv
// Simon game control FSM: stores player patterns, plays them back,
// checks the player's repeat and reports win/loss.
module simon_sequencer
   import simon_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   input  logic              level,
   input  logic [DATA_W-1:0] pattern,
   input  logic [DATA_W-1:0] mem_r_data,
   output logic [ADDR_W-1:0] mem_r_addr,
   output logic [ADDR_W-1:0] mem_w_addr,
   output logic [DATA_W-1:0] mem_w_data,
   output logic              mem_w_en,
   output logic [DATA_W-1:0] pattern_leds,
   output logic [3:0]        mode_leds,
   output logic              game_over
);

   localparam int CW    = ADDR_W + 1;
   localparam int DEPTH = 2 ** ADDR_W;

   state_e            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              lvl_q, lvl_d;

   logic              eff_lvl;
   logic              legal;
   logic [CW-1:0]     cnt_last;
   logic              at_last;
   logic              full;
   logic              match;

   assign eff_lvl  = (count_q == '0) ? level : lvl_q;
   assign legal    = is_legal(32'(pattern), eff_lvl);
   assign cnt_last = count_q - CW'(1);
   assign at_last  = ({1'b0, idx_q} == cnt_last);
   assign full     = (count_q == CW'(DEPTH));
   assign match    = (pattern == mem_r_data);

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      idx_d        = idx_q;
      lvl_d        = lvl_q;
      mem_r_addr   = '0;
      mem_w_addr   = count_q[ADDR_W-1:0];
      mem_w_data   = pattern;
      mem_w_en     = 1'b0;
      pattern_leds = pattern;
      mode_leds    = mode_leds_of(state_q);
      game_over    = 1'b0;

      unique case (state_q)
         ST_INPUT: begin
            // rst gating aborts a write that coincides with reset
            mem_w_en = step & legal & rst;
            if (legal) begin
               count_d = count_q + CW'(1);
               idx_d   = '0;
               state_d = ST_PLAYBACK;
               if (count_q == '0) lvl_d = level;
            end
         end
         ST_PLAYBACK: begin
            mem_r_addr   = idx_q;
            pattern_leds = mem_r_data;
            if (at_last) begin
               idx_d   = '0;
               state_d = ST_REPEAT;
            end else begin
               idx_d = idx_q + ADDR_W'(1);
            end
         end
         ST_REPEAT: begin
            mem_r_addr = idx_q;
            if (!match) begin
               idx_d   = '0;
               state_d = ST_DONE;
            end else if (at_last) begin
               idx_d   = '0;
               state_d = full ? ST_DONE : ST_INPUT;
            end else begin
               idx_d = idx_q + ADDR_W'(1);
            end
         end
         ST_DONE: begin
            mem_r_addr   = idx_q;
            pattern_leds = mem_r_data;
            game_over    = 1'b1;
            idx_d        = at_last ? '0 : idx_q + ADDR_W'(1);
         end
         default: state_d = ST_INPUT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_INPUT;
         count_q <= '0;
         idx_q   <= '0;
         lvl_q   <= 1'b0;
      end else if (step) begin
         state_q <= state_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         lvl_q   <= lvl_d;
      end
   end

endmodule
